// File: rtl/ramb_s16_nibble_reader.sv
`default_nettype none
// ============================================================================
// ramb_s16_nibble_reader : reads 16-bit words from the RAM B port and streams
//                          them out as LSB-first nibbles over valid/ready.
// Revision: 1.0
// ============================================================================
module ramb_s16_nibble_reader #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              CLKA,
  input  logic              RSTB,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] ADDRB,
  output logic              ENB,
  output logic              WEB,
  input  logic [15:0]       DOB,
  output logic [3:0]        NIB,
  output logic              NIB_VALID,
  input  logic              NIB_READY
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    OUT  = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [15:0]       shreg;
  logic [1:0]        nib_cnt;
  logic              nib_take;
  logic              last_nib;

  assign nib_take = (state == OUT) && NIB_READY;
  assign last_nib = nib_take && (nib_cnt == 2'd3);

  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (START) begin
          state_next = (LEN == '0) ? FIN : RD;
        end
      end
      RD:  state_next = CAP;
      CAP: state_next = OUT;
      OUT: begin
        if (last_nib) begin
          state_next = (remaining != '0) ? RD : FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // remaining is decremented when a word is captured, so it already counts
  // the words still to fetch once the current word drains.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      addr      <= '0;
      remaining <= '0;
      shreg     <= '0;
      nib_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            addr      <= BASE;
            remaining <= LEN;
          end
        end
        CAP: begin
          shreg     <= DOB;
          nib_cnt   <= '0;
          remaining <= remaining - LEN_W'(1);
        end
        OUT: begin
          if (nib_take) begin
            shreg   <= shreg >> 4;
            nib_cnt <= nib_cnt + 2'd1;
            if (last_nib && (remaining != '0)) begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign BUSY      = (state != IDLE);
  assign DONE      = (state == FIN);
  assign ENB       = (state == RD);
  assign WEB       = 1'b0;
  assign ADDRB     = addr;
  assign NIB       = shreg[3:0];
  assign NIB_VALID = (state == OUT);

endmodule
`default_nettype wire

// File: tb/tb_ramb_s16_nibble_reader.sv
`default_nettype none
// Directed testbench for ramb_s16_nibble_reader with a behavioural 256x16 RAM.
module tb_ramb_s16_nibble_reader;

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base = '0;
  logic [8:0]  len = '0;
  logic        busy, done, enb, web, nib_valid;
  logic [7:0]  addrb;
  logic [15:0] dob = '0;
  logic [3:0]  nib;
  logic        nib_ready = 1'b0;

  logic [15:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] nibs [$];
  logic [7:0] addrs [$];
  int         n_done;
  int         n_unstable;

  always #5 clk = ~clk;

  always @(posedge clk) if (enb) dob <= mem[addrb];

  ramb_s16_nibble_reader #(.ADDR_W(8), .LEN_W(9)) dut (
    .CLKA(clk), .RSTB(rstb), .START(start), .BASE(base), .LEN(len),
    .BUSY(busy), .DONE(done), .ADDRB(addrb), .ENB(enb), .WEB(web),
    .DOB(dob), .NIB(nib), .NIB_VALID(nib_valid), .NIB_READY(nib_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Starts a run at a falling edge and samples every following cycle until
  // BUSY drops; optionally pulses a second START at cycle dup_at.
  task automatic run(input logic [7:0] b, input logic [8:0] l, input bit rnd, input int dup_at);
    bit prev_valid, prev_ready, finished;
    logic [3:0] prev_nib;
    nibs.delete(); addrs.delete();
    n_done = 0; n_unstable = 0; finished = 0;
    prev_valid = 0; prev_ready = 0; prev_nib = '0;
    @(negedge clk);
    start = 1'b1; base = b; len = l;
    nib_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      start = (c == dup_at);
      if (c == dup_at) begin
        base = 8'h80; len = 9'd5;
      end
      if (prev_valid && !prev_ready && (!nib_valid || nib != prev_nib)) n_unstable++;
      if (enb) addrs.push_back(addrb);
      if (done) n_done++;
      nib_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (nib_valid && nib_ready) nibs.push_back(nib);
      prev_valid = nib_valid; prev_ready = nib_ready; prev_nib = nib;
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    check("run_terminates", 32'(finished), 32'd1);
  endtask

  task automatic check_nibs(input string tag, input logic [63:0] exp_seq, input int n);
    logic [3:0] got;
    check({tag, "_count"}, nibs.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < nibs.size()) ? nibs[i] : 4'hx;
      check($sformatf("%s_nib%0d", tag, i), 32'(got), 32'(exp_seq[4*i +: 4]));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
    mem[8'h10] = 16'hA5C3;
    mem[8'hFF] = 16'h1234;
    mem[8'h00] = 16'hBEEF;
    mem[8'h40] = 16'h1357;
    mem[8'h41] = 16'h9BDF;
    mem[8'h42] = 16'h0F0F;

    // Reset state
    rstb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_enb_1", 32'(enb), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_enb", 32'(enb), 32'd0);
    check("rst_web", 32'(web), 32'd0);
    check("rst_valid", 32'(nib_valid), 32'd0);
    check("rst_addrb", 32'(addrb), 32'd0);
    check("rst_nib", 32'(nib), 32'd0);
    rstb = 1'b0;
    @(negedge clk);

    // Single word with exact cycle timing
    start = 1'b1; base = 8'h10; len = 9'd1; nib_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_enb_k1", 32'(enb), 32'd1);
    check("t1_addrb_k1", 32'(addrb), 32'h10);
    check("t1_busy_k1", 32'(busy), 32'd1);
    check("t1_valid_k1", 32'(nib_valid), 32'd0);
    @(negedge clk);
    check("t1_enb_k2", 32'(enb), 32'd0);
    check("t1_valid_k2", 32'(nib_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] w;
      w = 16'hA5C3;
      @(negedge clk);
      check($sformatf("t1_valid_k%0d", i + 3), 32'(nib_valid), 32'd1);
      check($sformatf("t1_nib_k%0d", i + 3), 32'(nib), 32'(w[4*i +: 4]));
      check($sformatf("t1_done_k%0d", i + 3), 32'(done), 32'd0);
    end
    @(negedge clk);
    check("t1_done_k7", 32'(done), 32'd1);
    check("t1_valid_k7", 32'(nib_valid), 32'd0);
    check("t1_busy_k7", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_done_k8", 32'(done), 32'd0);
    check("t1_busy_k8", 32'(busy), 32'd0);

    // Address wrap 0xFF -> 0x00
    run(8'hFF, 9'd2, 1'b0, -1);
    check("wrap_addr_cnt", addrs.size(), 2);
    if (addrs.size() >= 2) begin
      check("wrap_addr0", 32'(addrs[0]), 32'hFF);
      check("wrap_addr1", 32'(addrs[1]), 32'h00);
    end
    check_nibs("wrap", 64'hBEEF_1234, 8);
    check("wrap_done", n_done, 1);

    // Backpressure over three words
    run(8'h40, 9'd3, 1'b1, -1);
    check_nibs("bp", {16'h0, 16'h0F0F, 16'h9BDF, 16'h1357}, 12);
    check("bp_unstable", n_unstable, 0);
    check("bp_done", n_done, 1);

    // LEN = 0
    @(negedge clk);
    start = 1'b1; base = 8'h33; len = 9'd0; nib_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_done_k1", 32'(done), 32'd1);
    check("len0_enb_k1", 32'(enb), 32'd0);
    check("len0_valid_k1", 32'(nib_valid), 32'd0);
    @(negedge clk);
    check("len0_busy_k2", 32'(busy), 32'd0);
    check("len0_done_k2", 32'(done), 32'd0);

    // Second START during a 3-word run is ignored
    run(8'h20, 9'd3, 1'b0, 5);
    check("ign_addr_cnt", addrs.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("ign_addr%0d", i), (i < addrs.size()) ? 32'(addrs[i]) : 32'hFFFF, 32'(8'h20 + i));
    check("ign_done", n_done, 1);
    check_nibs("ign", {16'h0, 16'h2222, 16'h2121, 16'h2020}, 12);

    // Reset in the middle of the second nibble
    @(negedge clk);
    start = 1'b1; base = 8'h10; len = 9'd1; nib_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mrst_nib2", 32'(nib), 32'hC);
    rstb = 1'b1; nib_ready = 1'b0;
    @(negedge clk);
    check("mrst_valid", 32'(nib_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    rstb = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mrst_no_done", n_done, 0);
    run(8'h10, 9'd1, 1'b0, -1);
    check_nibs("after_rst", 64'h0000_0000_0000_A5C3, 4);
    check("after_rst_done", n_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
